// File: rtl/ternary_pkg.sv
// ternary_pkg
//   Shared trit encoding for the ternary datapath. Two bits per trit;
//   the fourth code marks a corrupted or uninitialised trit.
package ternary_pkg;

  typedef enum logic [1:0] {
    T_ZERO    = 2'b00,
    T_POS_ONE = 2'b01,
    T_NEG_ONE = 2'b10,
    T_INVALID = 2'b11
  } trit_t;

endpackage

// File: rtl/ternary_to_bin_seq.sv
// ternary_to_bin_seq
//   Sequential balanced-ternary to two's-complement converter. A captured
//   WIDTH-trit word is folded most-significant trit first (acc = acc*3 + v)
//   one trit per cycle, then the signed result is presented with zero,
//   negative and invalid-trit flags under a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    in_trits holds a word to convert
//   in_ready    converter idle and able to capture a word
//   in_trits    input word, index WIDTH-1 is the most significant trit
//   out_valid   result available
//   out_ready   consumer takes the result
//   out_value   signed binary value of the word
//   out_zero    out_value == 0
//   out_neg     out_value < 0
//   out_invalid at least one input trit was T_INVALID
module ternary_to_bin_seq
  import ternary_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BIN_WIDTH = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  trit_t [WIDTH-1:0]           in_trits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIN_WIDTH-1:0] out_value,
  output logic                        out_zero,
  output logic                        out_neg,
  output logic                        out_invalid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Largest magnitude a WIDTH-trit word can reach: (3^WIDTH - 1) / 2.
  function automatic longint max_mag(input int w);
    longint p;
    p = 64'sd1;
    for (int i = 0; i < w; i++) begin
      p = p * 64'sd3;
    end
    return (p - 64'sd1) / 64'sd2;
  endfunction

  localparam longint MAX_MAG = max_mag(WIDTH);
  localparam longint BIN_MAX = (64'sd1 <<< (BIN_WIDTH - 1)) - 64'sd1;

  // Refuse to build a converter whose accumulator could overflow.
  generate
    if (BIN_MAX < MAX_MAG) begin : g_bin_width_too_small
      $error("ternary_to_bin_seq: BIN_WIDTH too small for WIDTH trits");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  trit_t [WIDTH-1:0]           r_shadow;
  logic signed [BIN_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_inv;

  logic [WIDTH-1:0]            w_is_pos;
  logic [WIDTH-1:0]            w_is_neg;
  logic [WIDTH-1:0]            w_is_inv;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_sel_inv;
  logic signed [BIN_WIDTH-1:0] w_trit_val;
  logic signed [BIN_WIDTH-1:0] w_acc_next;
  logic                        w_inv_next;

  // Per-trit class decode of the shadow word; the active trit is then
  // picked by the down-counter.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_trit_decode
      assign w_is_pos[gi] = (r_shadow[gi] == T_POS_ONE);
      assign w_is_neg[gi] = (r_shadow[gi] == T_NEG_ONE);
      assign w_is_inv[gi] = (r_shadow[gi] == T_INVALID);
    end
  endgenerate

  // in_ready is held low while reset is asserted so a word presented
  // together with reset is never captured.
  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == '0);
  assign w_sel_inv = w_is_inv[r_cnt];

  // T_INVALID contributes 0, like T_ZERO, and only raises the flag.
  always_comb begin
    w_trit_val = '0;
    if (w_is_pos[r_cnt]) begin
      w_trit_val = {{(BIN_WIDTH-1){1'b0}}, 1'b1};
    end else if (w_is_neg[r_cnt]) begin
      w_trit_val = '1;
    end
  end

  // acc*3 computed as (acc<<1)+acc; never overflows for a legal BIN_WIDTH.
  assign w_acc_next = (r_acc <<< 1) + r_acc + w_trit_val;
  assign w_inv_next = r_inv | w_sel_inv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)  w_state_next = S_CONV;
      S_CONV: if (w_last)    w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  // The shadow word is the only input read during conversion, so in_trits
  // may change freely once the word is accepted. The result registers are
  // loaded once, on the final CONV cycle, and hold through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_inv       <= 1'b0;
      out_value   <= '0;
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      out_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shadow <= in_trits;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_inv    <= 1'b0;
          end
        end
        S_CONV: begin
          r_acc <= w_acc_next;
          r_inv <= w_inv_next;
          if (!w_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            out_value   <= w_acc_next;
            out_zero    <= (w_acc_next == '0);
            out_neg     <= w_acc_next[BIN_WIDTH-1];
            out_invalid <= w_inv_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_to_bin_seq.sv
// tb_ternary_to_bin_seq
//   Directed and random words converted through ternary_to_bin_seq and
//   compared against a positional-weight model of balanced ternary.
module tb_ternary_to_bin_seq;
  import ternary_pkg::*;

  localparam int WIDTH     = 8;
  localparam int BIN_WIDTH = 13;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  trit_t [WIDTH-1:0]           in_trits;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [BIN_WIDTH-1:0] out_value;
  logic                        out_zero;
  logic                        out_neg;
  logic                        out_invalid;

  int n_vectors;
  int n_miscompares;

  ternary_to_bin_seq #(
    .WIDTH     (WIDTH),
    .BIN_WIDTH (BIN_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_trits    (in_trits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_invalid (out_invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of trit weight 3^i times its value, invalid counts as 0.
  function automatic longint ref_value(input trit_t [WIDTH-1:0] w);
    longint s;
    longint wt;
    s  = 0;
    wt = 1;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i] == T_POS_ONE) s = s + wt;
      else if (w[i] == T_NEG_ONE) s = s - wt;
      wt = wt * 3;
    end
    return s;
  endfunction

  function automatic bit ref_invalid(input trit_t [WIDTH-1:0] w);
    bit any;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i] == T_INVALID) any = 1'b1;
    end
    return any;
  endfunction

  function automatic trit_t [WIDTH-1:0] fill_word(input trit_t t);
    trit_t [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[i] = t;
    return w;
  endfunction

  function automatic trit_t [WIDTH-1:0] random_word();
    trit_t [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) begin
      if ($urandom_range(0, 9) == 0) w[i] = T_INVALID;
      else begin
        case ($urandom_range(0, 2))
          0:       w[i] = T_ZERO;
          1:       w[i] = T_POS_ONE;
          default: w[i] = T_NEG_ONE;
        endcase
      end
    end
    return w;
  endfunction

  // Called and returns on a falling edge. Presents w, checks latency and
  // result, holds out_ready low for 'hold' cycles (optionally offering
  // w_next meanwhile), then consumes the result.
  task automatic run_word(input string tag, input trit_t [WIDTH-1:0] w,
                          input int hold, input bit queue_next,
                          input trit_t [WIDTH-1:0] w_next);
    int     guard;
    int     lat;
    longint exp_val;
    bit     exp_inv;
    exp_val = ref_value(w);
    exp_inv = ref_invalid(w);
    in_valid = 1'b1;
    in_trits = w;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept"}, {63'd0, in_ready}, 64'sd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_trits = random_word();
    chk({tag, "_conv_rdy"}, {63'd0, in_ready}, 64'sd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      in_trits = random_word();
    end
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
    chk({tag, "_value"},   64'($signed(out_value)), exp_val);
    chk({tag, "_zero"},    {63'd0, out_zero},    {63'd0, exp_val == 0});
    chk({tag, "_neg"},     {63'd0, out_neg},     {63'd0, exp_val < 0});
    chk({tag, "_invalid"}, {63'd0, out_invalid}, {63'd0, exp_inv});
    chk({tag, "_done_rdy"}, {63'd0, in_ready}, 64'sd0);
    $display("word %s: value=%0d zero=%0b neg=%0b invalid=%0b (model %0d)",
             tag, out_value, out_zero, out_neg, out_invalid, exp_val);
    if (queue_next) begin
      in_valid = 1'b1;
      in_trits = w_next;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'sd1);
      chk({tag, "_hold_value"}, 64'($signed(out_value)), exp_val);
      chk({tag, "_hold_rdy"},   {63'd0, in_ready}, 64'sd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed"}, {63'd0, out_valid}, 64'sd0);
    chk({tag, "_idle_rdy"}, {63'd0, in_ready}, 64'sd1);
  endtask

  initial begin
    trit_t [WIDTH-1:0] w;
    trit_t [WIDTH-1:0] w2;
    bit                seen;
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_trits  = fill_word(T_ZERO);

    repeat (3) @(negedge clk);
    chk("rst_valid",   {63'd0, out_valid},   64'sd0);
    chk("rst_value",   64'($signed(out_value)), 64'sd0);
    chk("rst_zero",    {63'd0, out_zero},    64'sd0);
    chk("rst_neg",     {63'd0, out_neg},     64'sd0);
    chk("rst_invalid", {63'd0, out_invalid}, 64'sd0);
    chk("rst_ready",   {63'd0, in_ready},    64'sd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, in_ready}, 64'sd1);

    // Directed words.
    w = fill_word(T_ZERO);
    run_word("all_zero", w, 0, 1'b0, w);
    w = fill_word(T_POS_ONE);
    run_word("all_pos", w, 0, 1'b0, w);
    chk("all_pos_const", 64'($signed(out_value)), 64'sd3280);
    w = fill_word(T_NEG_ONE);
    run_word("all_neg", w, 0, 1'b0, w);
    chk("all_neg_const", 64'($signed(out_value)), -64'sd3280);
    w = fill_word(T_ZERO);
    w[2] = T_POS_ONE;
    w[0] = T_NEG_ONE;
    run_word("eight", w, 0, 1'b0, w);
    chk("eight_const", 64'($signed(out_value)), 64'sd8);
    w = fill_word(T_POS_ONE);
    w[WIDTH-1] = T_NEG_ONE;
    run_word("mst_neg", w, 0, 1'b0, w);
    chk("mst_neg_const", 64'($signed(out_value)), -64'sd1094);
    w = fill_word(T_ZERO);
    w[3] = T_INVALID;
    run_word("inv3", w, 0, 1'b0, w);
    chk("inv3_flag", {63'd0, out_invalid}, 64'sd1);
    w = fill_word(T_ZERO);
    w[5] = T_POS_ONE;
    w[1] = T_NEG_ONE;
    run_word("after_inv", w, 0, 1'b0, w);

    // Backpressure in DONE with the next word already offered.
    w  = random_word();
    w2 = fill_word(T_NEG_ONE);
    w2[4] = T_POS_ONE;
    run_word("stall", w, 5, 1'b1, w2);
    run_word("stall_next", w2, 0, 1'b0, w2);

    // Reset in CONV cycle 4, with in_valid high during reset.
    in_valid = 1'b1;
    in_trits = fill_word(T_POS_ONE);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_valid", {63'd0, out_valid}, 64'sd0);
      chk("midrst_value", 64'($signed(out_value)), 64'sd0);
      chk("midrst_neg",   {63'd0, out_neg},   64'sd0);
      chk("midrst_ready", {63'd0, in_ready},  64'sd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    seen     = 1'b0;
    repeat (WIDTH + 3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {63'd0, seen}, 64'sd0);
    chk("midrst_ready_after", {63'd0, in_ready}, 64'sd1);
    w = random_word();
    run_word("after_rst", w, 0, 1'b0, w);

    // Random words, random stalls, alternating back-to-back offers.
    w = random_word();
    for (int k = 0; k < 40; k++) begin
      w2 = random_word();
      run_word($sformatf("rnd%0d", k), w, $urandom_range(0, 2), k[0], w2);
      w = w2;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
